mc_controller: RTL
==================

// Module: mc_controller
// PURPOSE
//  Multicycle control FSM for the RV32I core; sits directly upstream of the datapath and drives all of its enables and mux selects.
//  Consumes op/funct3/funct7b5/Zero from the datapath and sequences fetch, decode, execute, memory and writeback states.
//  Adds programmable wait cycles for block-RAM latency and a sticky illegal-instruction halt.
// PARAMETERS
//  FETCH_WAIT  0  extra cycles FETCH holds before IRWrite/PCWrite fire (0..15)
//  MEM_WAIT    0  extra cycles MEMREAD holds before advancing to MEMWB (0..15)
// PORTS
//  clk        in   1  core clock; all state updates on posedge
//  resetn     in   1  asynchronous active-low reset
//  op         in   7  opcode (Instr[6:0])
//  funct3     in   3  Instr[14:12]
//  funct7b5   in   1  Instr[30]
//  Zero       in   1  ALU zero flag
//  PCWrite    out  1  PC register enable
//  AdrSrc     out  1  0 = PC, 1 = Result drives the memory address
//  MemWrite   out  1  RAM write enable
//  IRWrite    out  1  Instr/OldPC register enable
//  ResultSrc  out  2  00 ALUOut, 01 data, 10 ALUResult
//  ALUControl out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
//  ALUSrcB    out  2  00 rs2 (WriteData), 01 ImmExt, 10 constant 4
//  ALUSrcA    out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
//  ImmSrc     out  3  000 I, 001 S, 010 B, 011 J, 100 U
//  RegWrite   out  1  register-file write enable
//  halted     out  1  sticky; high in the ERROR state
// BEHAVIOUR
//  Reset: state = FETCH, wait counter = 0.
//  While resetn = 0: PCWrite, MemWrite, IRWrite, RegWrite, halted = 0; every select = 0.
//  The first FETCH cycle occurs on the first posedge after resetn rises.
//  Reset asserted mid-instruction aborts it immediately; no partial write completes after reset assertion.
//  ImmSrc is combinational from op in every state: lw/jalr/OP-IMM = I, sw = S, branch = B, jal = J, lui/auipc = U, otherwise I.
//  Outputs are Moore (from state only), with two exceptions:
//   - PCWrite in BRANCH depends on Zero.
//   - ALUControl in EXEC_R/EXEC_I depends on funct3/funct7b5.
//  Unlisted outputs are 0 in each state.
//  FETCH:
//   - Outputs: AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, add, ResultSrc = 10.
//   - The wait counter counts FETCH_WAIT cycles. IRWrite = PCWrite = 1 only in the final FETCH cycle, then -> DECODE.
//  DECODE: ALUSrcA = 01, ALUSrcB = 01, add (ALUOut = OldPC + imm). Next state by op:
//   - 0000011 / 0100011 -> MEMADR
//   - 0110011 -> EXEC_R
//   - 0010011 -> EXEC_I
//   - 1100011 -> BRANCH
//   - 1101111 -> JAL
//   - 1100111 -> JALR
//   - 0110111 -> LUI
//   - 0010111 -> AUIPC
//   - any other op -> ERROR
//  MEMADR: ALUSrcA = 10, ALUSrcB = 01, add. lw -> MEMREAD; sw -> MEMWRITE.
//  MEMREAD: AdrSrc = 1, ResultSrc = 00. Holds MEM_WAIT extra cycles, then -> MEMWB.
//  MEMWB: ResultSrc = 01, RegWrite = 1 -> FETCH.
//  MEMWRITE: AdrSrc = 1, ResultSrc = 00, MemWrite = 1 for exactly one cycle -> FETCH.
//  EXEC_R / EXEC_I: ALUSrcA = 10, ALUSrcB = 00 (R) or 01 (I) -> ALUWB. ALUControl from funct3:
//   - 000: sub only when R-type and funct7b5 = 1, otherwise add
//   - 001 sll, 010 slt, 100 xor, 101 srl (sra executes as srl), 110 or, 111 and
//   - 011 -> slt
//  ALUWB: ResultSrc = 00, RegWrite = 1 -> FETCH.
//  BRANCH: ALUSrcA = 10, ALUSrcB = 00, sub, ResultSrc = 00 -> FETCH.
//   - PCWrite = Zero for funct3 000, !Zero for 001, 0 for any other funct3.
//  JAL: ALUSrcA = 01, ALUSrcB = 10, add, ResultSrc = 00, PCWrite = 1 -> ALUWB (writes back OldPC + 4).
//  JALR: ALUSrcA = 10, ALUSrcB = 01, add (ALUOut = rs1 + imm) -> JAL.
//  LUI: ALUSrcA = 11, ALUSrcB = 01, add -> ALUWB.
//  AUIPC: ALUSrcA = 01, ALUSrcB = 01, add -> ALUWB.
//  ERROR: halted = 1, all enables 0. Sticky until resetn.
//  Wait counter: 4-bit, cleared on every state entry, never wraps. A WAIT value of 0 gives a single-cycle state.
//  CPI (WAIT = 0): lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui/auipc 4.
// TESTING
//  T1 reset then lw (op 0000011):
//   -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH.
//   -> RegWrite = 1 with ResultSrc = 01 in cycle 5 only.
//  T2 beq (funct3 000):
//   -> Zero = 1: PCWrite = 1 in BRANCH.
//   -> Zero = 0: PCWrite = 0.
//   -> bne (001) with Zero = 0: PCWrite = 1.
//  T3 R-type funct3 000 with funct7b5 = 1 -> ALUControl = 001. I-type with funct7b5 = 1 -> ALUControl = 000.
//  T4 FETCH_WAIT = 2, MEM_WAIT = 3, lw:
//   -> IRWrite asserted only in the 3rd FETCH cycle.
//   -> MEMREAD lasts 4 cycles; total 10 cycles.
//  T5 op 1111111:
//   -> ERROR after DECODE; halted = 1 held for 20+ cycles with all enables 0.
//   -> resetn pulse returns to FETCH.
//  T6 resetn dropped during MEMWRITE:
//   -> MemWrite falls asynchronously, before the next clk edge.
//   -> FETCH on the first edge after release.

Source files
------------

// File: rtl/mc_controller_if.sv
// Control/status bundle between the multicycle controller and the RV32I datapath.
// The controller drives the master side; the datapath drives opcode fields and Zero.
interface mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [2:0] ALUControl;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUSrcA;
    logic [2:0] ImmSrc;
    logic       RegWrite;
    logic       halted;

    modport master (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrcB, ALUSrcA, ImmSrc, RegWrite, halted
    );

    modport slave (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
               ALUSrcB, ALUSrcA, ImmSrc, RegWrite, halted
    );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I control FSM with programmable FETCH/MEMREAD wait cycles and sticky illegal-op halt.
// Outputs follow the current state (BRANCH PCWrite and EXEC ALUControl also see inputs); no backpressure.
module mc_controller #(
    parameter int unsigned FETCH_WAIT = 0,
    parameter int unsigned MEM_WAIT   = 0
) (
    input  logic            clk,
    input  logic            resetn,
    mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
        S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_ERROR
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [3:0] FETCH_LAST = 4'(FETCH_WAIT);
    localparam logic [3:0] MEM_LAST   = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       run_q;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, halt;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_ctrl, imm_src;

    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_dec = sub ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLT;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

    always_comb begin
        case (bus.op)
            OP_SW:            imm_src = 3'b001;
            OP_BR:            imm_src = 3'b010;
            OP_JAL:           imm_src = 3'b011;
            OP_LUI, OP_AUIPC: imm_src = 3'b100;
            default:          imm_src = 3'b000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        halt       = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (cnt_q == FETCH_LAST) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    OP_LUI:       state_d = S_LUI;
                    OP_AUIPC:     state_d = S_AUIPC;
                    default:      state_d = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (cnt_q == MEM_LAST) state_d = S_MEMWB;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = (state_q == S_EXEC_I) ? 2'b01 : 2'b00;
                alu_ctrl  = alu_dec(bus.funct3, bus.funct7b5 && (state_q == S_EXEC_R));
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                pc_write  = (bus.funct3 == 3'b000) ? bus.Zero :
                            (bus.funct3 == 3'b001) ? !bus.Zero : 1'b0;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_JAL;
            end
            S_LUI, S_AUIPC: begin
                alu_src_a = (state_q == S_LUI) ? 2'b11 : 2'b01;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_ERROR: halt = 1'b1;
            default: state_d = S_ERROR;
        endcase
    end

    // run_q holds the FSM in FETCH and masks every output until the first edge after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (run_q) begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end
    end

    assign bus.PCWrite    = run_q & pc_write;
    assign bus.AdrSrc     = run_q & adr_src;
    assign bus.MemWrite   = run_q & mem_write;
    assign bus.IRWrite    = run_q & ir_write;
    assign bus.RegWrite   = run_q & reg_write;
    assign bus.halted     = run_q & halt;
    assign bus.ResultSrc  = run_q ? result_src : 2'b00;
    assign bus.ALUControl = run_q ? alu_ctrl   : 3'b000;
    assign bus.ALUSrcB    = run_q ? alu_src_b  : 2'b00;
    assign bus.ALUSrcA    = run_q ? alu_src_a  : 2'b00;
    assign bus.ImmSrc     = run_q ? imm_src    : 3'b000;
endmodule
